// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the serial receive and transmit paths:
//   - rx_state_e   : receiver FSM state encoding
//   - LINE_IDLE    : idle (mark) level of the serial line
//   - clks_per_bit : reference clocks per bit for a given clock/baud pair
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;

    // refclk_mhz in MHz, baud in bit/s; result is floored.
    function automatic int clks_per_bit(input int refclk_mhz, input int baud);
        return (refclk_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output (2 clk_i edges of latency)
// RST_VAL sets the value both flops take in reset.
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver, start + DATA_W bits (LSB first) + 1 stop.
//   ref_clk    : reference clock (only clock)
//   resetn     : asynchronous active-low reset
//   rxd        : serial line, idle high, asynchronous to ref_clk
//   dout       : last correctly received word (holds between frames)
//   dout_valid : one-cycle pulse when dout is updated
//   frame_err  : one-cycle pulse on a low stop bit
//   parity_err : one-cycle pulse on an even-parity mismatch
//   busy       : high whenever the FSM is not idle
// Optional feature macro UART_RX_PARITY_EN inserts an even-parity bit
// between the data and the stop bit. Without it parity_err is tied 0.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int REFCLK_F  = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_W    = 8
) (
    input  logic              ref_clk,
    input  logic              resetn,
    input  logic              rxd,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(REFCLK_F, BAUD_RATE);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_W - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
        $error("uart_rx: DATA_W must be in 5..9");
    end

    logic rxd_s;
    logic rxd_d_q;

    sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
        .clk_i  (ref_clk),
        .rst_ni (resetn),
        .d_i    (rxd),
        .q_o    (rxd_s)
    );

    // Delayed copy of the synchronised line for falling-edge detection.
    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) rxd_d_q <= LINE_IDLE;
        else         rxd_d_q <= rxd_s;
    end

    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        bits_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic              ferr_q;
    logic              busy_q;
`ifdef UART_RX_PARITY_EN
    logic              perr_q;
    logic              pbad_q;
`endif

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            // Status flags are single-cycle pulses.
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            cnt_q  <= cnt_q + CNT_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (rxd_d_q && !rxd_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        pbad_q  <= 1'b0;
`endif
                    end
                end

                // Mid start bit: a high line here was a glitch, not a frame.
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q  <= '0;
                        bits_q <= '0;
                        if (!rxd_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                // Right shift with new bit at the MSB: LSB-first bit ends at [0].
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rxd_s, shreg_q[DATA_W-1:1]};
                        bits_q  <= bits_q + 4'd1;
                        if (bits_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        pbad_q  <= rxd_s ^ (^shreg_q);
                        state_q <= ST_STOP;
                    end
                end
`endif

                // Leaving at mid stop bit lets a back-to-back start edge be seen.
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (pbad_q) begin
                                perr_q <= 1'b1;
                            end else begin
                                dout_q <= shreg_q;
                                vld_q  <= 1'b1;
                            end
`else
                            dout_q <= shreg_q;
                            vld_q  <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end
                end

                // Hold off until the line is released so a stuck-low line
                // cannot be mistaken for a stream of start bits.
                ST_BREAK: begin
                    if (rxd_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 50 MHz / 115200 baud (434 clk/bit).
// A frame-level reference model predicts, for every frame sent, which flag
// pulses, when it pulses (relative to the start edge), the word on dout and
// how long busy stays high.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DW   = 8;
    localparam int CPB  = (50 * 1000000) / 115200;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Start drive -> flag visible: 2 sync edges + 1 FSM edge, then HALF to
    // mid start bit and one bit period per data/parity/stop slot.
    localparam int LAT      = 3 + HALF + (DW + 1 + PB) * CPB;
    localparam int BUSY_LEN = HALF + (DW + 1 + PB) * CPB;
    localparam int FRAME    = (DW + 2 + PB) * CPB;

    localparam logic [2:0] F_VLD  = 3'b001;
    localparam logic [2:0] F_FERR = 3'b010;
    localparam logic [2:0] F_PERR = 3'b100;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rxd;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx #(.REFCLK_F(50), .BAUD_RATE(115200), .DATA_W(DW)) dut (
        .ref_clk    (clk),
        .resetn     (resetn),
        .rxd        (rxd),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [2:0]    flags;
        logic [DW-1:0] word;
    } ev_t;

    ev_t  evq[$];
    int   cyc      = 0;
    int   busy_tot = 0;
    int   n_chk    = 0;
    int   n_err    = 0;
    logic [DW-1:0] last_word;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_tot <= busy_tot + 1;
        if (dout_valid || frame_err || parity_err)
            evq.push_back('{cyc: cyc, flags: {parity_err, frame_err, dout_valid}, word: dout});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends one frame starting at a negedge and checks the outcome against
    // the frame rules. A low stop bit leaves the line low for a while to
    // exercise the break hold-off before releasing it.
    task automatic run_frame(input string tag, input logic [DW-1:0] data,
                             input logic par, input logic stop);
        int         ev0, b0, ts;
        logic [2:0] exp_f;
        ev0 = evq.size();
        b0  = busy_tot;
        ts  = cyc;
        bit_time(1'b0);
        for (int i = 0; i < DW; i++) bit_time(data[i]);
        if (PB != 0) bit_time(par);
        bit_time(stop);

        if (!stop)                          exp_f = F_FERR;
        else if (PB != 0 && par != ^data)   exp_f = F_PERR;
        else                                exp_f = F_VLD;
        if (exp_f == F_VLD) last_word = data;

        chk({tag, "_nev"}, evq.size() - ev0, 1);
        if (evq.size() > ev0) begin
            chk({tag, "_flags"}, evq[ev0].flags, exp_f);
            chk({tag, "_lat"}, evq[ev0].cyc - ts, LAT);
            if (exp_f == F_VLD) chk({tag, "_word"}, evq[ev0].word, data);
        end
        chk({tag, "_dout"}, dout, last_word);

        if (stop) begin
            chk({tag, "_busy_end"}, busy, 0);
            chk({tag, "_busy_len"}, busy_tot - b0, BUSY_LEN);
        end else begin
            repeat (2 * CPB) @(negedge clk);
            chk({tag, "_brk_busy"}, busy, 1);
            chk({tag, "_brk_nev"}, evq.size() - ev0, 1);
            rxd = 1'b1;
            repeat (4) @(negedge clk);
            chk({tag, "_brk_exit"}, busy, 0);
            repeat (CPB) @(negedge clk);
            chk({tag, "_brk_quiet"}, evq.size() - ev0, 1);
        end
    endtask

    initial begin
        int            b0, ev0, i1, i2;
        logic [DW-1:0] d;
        logic          s;

        rxd       = 1'b1;
        resetn    = 1'b0;
        last_word = '0;
        repeat (5) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_flags", {dout_valid, frame_err, parity_err}, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        repeat (20) @(negedge clk);

        run_frame("a5", 8'hA5, ^8'hA5, 1'b1);
        repeat (CPB) @(negedge clk);

        // Short low glitch: false start, back to idle after half a bit.
        ev0 = evq.size();
        b0  = busy_tot;
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_nev", evq.size() - ev0, 0);
        chk("glitch_busy_len", busy_tot - b0, HALF);
        chk("glitch_busy_end", busy, 0);

        run_frame("3c", 8'h3C, ^8'h3C, 1'b1);
        run_frame("81_ferr", 8'h81, ^8'h81, 1'b0);

        // Back-to-back frames with no idle gap.
        run_frame("b2b_00", 8'h00, 1'b0, 1'b1);
        i1 = evq.size() - 1;
        run_frame("b2b_ff", 8'hFF, 1'b0, 1'b1);
        i2 = evq.size() - 1;
        if (i1 >= 0 && i2 > i1) chk("b2b_gap", evq[i2].cyc - evq[i1].cyc, FRAME);
        repeat (CPB) @(negedge clk);

        // Reset in the middle of data bit 4.
        ev0 = evq.size();
        d   = 8'h5A;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(d[i]);
        rxd = d[4];
        repeat (CPB / 2) @(negedge clk);
        resetn = 1'b0;
        #1;
        last_word = '0;
        chk("midrst_dout", dout, 0);
        chk("midrst_flags", {dout_valid, frame_err, parity_err}, 0);
        chk("midrst_busy", busy, 0);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        resetn = 1'b1;
        repeat (CPB) @(negedge clk);
        chk("midrst_nev", evq.size() - ev0, 0);
        run_frame("5a", 8'h5A, ^8'h5A, 1'b1);

`ifdef UART_RX_PARITY_EN
        run_frame("par_bad", 8'h01, 1'b0, 1'b1);
        run_frame("par_ok", 8'h01, 1'b1, 1'b1);
`endif

        for (int n = 0; n < 5; n++) begin
            d = DW'($urandom_range(0, (1 << DW) - 1));
            s = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rnd%0d", n), d,
                      (PB != 0 && $urandom_range(0, 3) == 0) ? ~(^d) : ^d, s);
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
